ss_ddr_arbiter: RTL and testbench
=================================

// Module: ss_ddr_arbiter
// PURPOSE
//  Shares one 64-bit toggle-handshake DDRAM channel between two clients:
//  client 0 is the savestate engine, client 1 is a secondary streamer
//  (MSU/rewind). Each client keeps its own req/ack toggle pair.
//  Requests are serialised onto the upstream port, and each client's read
//  data is registered so it stays stable until that client's next read.
//  A lock input reserves the channel for client 0 while a savestate runs.
// PARAMETERS
//  AW     19   address width; word address, DDR byte address bits [21:3]
//  DW     64   data width
//  BEW     8   byte-enable width (DW/8)
//  RR      1   1 = round-robin between clients; 0 = fixed priority, client 0 wins
// PORTS
//  clk        in   1    system clock
//  reset_n    in   1    asynchronous reset, active-low
//  c0_req     in   1    client 0 request toggle; pending while c0_req != c0_ack
//  c0_ack     out  1    client 0 acknowledge toggle
//  c0_addr    in   AW   client 0 word address
//  c0_we      in   1    client 0 write (1) / read (0)
//  c0_be      in   BEW  client 0 byte enables
//  c0_wdata   in   DW   client 0 write data
//  c0_rdata   out  DW   client 0 registered read data
//  c0_lock    in   1    while high, client 1 is never granted (savestate ss_busy)
//  c1_*       --   --   client 1 port set; same signals and widths as c0_*, minus lock
//  m_req      out  1    upstream request toggle
//  m_ack      in   1    upstream acknowledge toggle
//  m_addr     out  AW   upstream address, registered at grant
//  m_we       out  1    upstream write strobe, registered at grant
//  m_be       out  BEW  upstream byte enables, registered at grant
//  m_wdata    out  DW   upstream write data, registered at grant
//  m_rdata    in   DW   upstream read data, valid when m_ack == m_req
//  busy       out  1    1 while state != IDLE
//  owner      out  1    client index of the current/last grant
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, last-grant = 1 (client 0 wins first tie).
//  - pendN = cN_req ^ cN_ack. elig1 = pend1 & ~c0_lock. elig0 = pend0.
//  - State IDLE:
//    - Neither client eligible: stay in IDLE.
//    - One client eligible: grant it.
//    - Both eligible: RR=1 grants the client not granted last; RR=0 grants client 0.
//    - Grant edge: latch addr/we/be/wdata of the winner into m_*; toggle m_req;
//      set owner; go to WAIT.
//  - State WAIT:
//    - Hold every m_* output stable.
//    - On the edge where m_req == m_ack:
//      - for a read, cN_rdata <= m_rdata;
//      - toggle cN_ack of the owner;
//      - go to IDLE.
//  - Latency: a pending request seen at edge k is issued at edge k+1. The client
//    ack toggles 1 cycle after the upstream ack. The next grant comes no earlier
//    than the cycle after completion (2-cycle minimum per transaction).
//  - cN_rdata changes only on that client's read completion.
//    Writes leave rdata untouched.
//  - A client toggling req again while its request is pending is a protocol
//    violation. It must not corrupt the other client. Result is undefined for the offender.
//  - c0_lock rising while client 1 is in WAIT: client 1 completes normally.
//    The lock only blocks new grants.
//  - c0_lock held with client 1 pending: client 1 stays pending indefinitely,
//    its ack is not toggled, and it is granted the first IDLE cycle after the lock drops.
//  - Simultaneous new request and completion of the same client in one cycle:
//    the request is evaluated in the next IDLE cycle.
//  - Reset mid-transaction: outputs clear asynchronously. The upstream
//    controller and both clients must share reset_n so all toggles realign to 0.
//  - No address translation. Clients own disjoint DDR regions.
// STRUCTURE
//  - Shared package ss_pkg: state enum {IDLE, WAIT}; localparams SS_DDR_AW=19,
//    SS_DDR_DW=64.
//  - One sub-module is natural: ss_rr_pick (2-way round-robin/priority pick,
//    combinational plus last-grant register).
//  - Datapath muxes and the FSM stay inline.
// TESTING
//  1. Client 0 read, addr 0x00001, m_rdata=64'h0000_0000_5345_4E53, upstream ack 3
//     cycles later -> m_req toggles once, m_addr=0x00001, m_we=0, c0_rdata=5345_4E53,
//     c0_ack toggles 1 cycle after m_ack.
//  2. Client 0 write be=8'hF0 and client 1 read toggle on the same edge, RR=1, after reset
//     -> client 0 issued first, client 1 second; c1_rdata captured; c0_rdata unchanged.
//  3. Back-to-back pending on both clients for 6 transactions, RR=1
//     -> grants alternate 0,1,0,1,0,1; RR=0 with client 0 always pending
//     -> client 1 starved until client 0 is idle.
//  4. c0_lock=1 with client 1 pending for 50 cycles -> no m_req toggle for client 1;
//     lock drops -> client 1 issued on the next edge.
//  5. Lock asserted during client 1 WAIT -> client 1 completes with its data;
//     a following client 0 request is granted immediately.
//  6. Assert reset_n low during WAIT -> m_req, acks, busy and rdata return to 0 at once;
//     after release a fresh client 0 read completes correctly.

Source files
------------

// File: rtl/ss_ddr_arbiter_pkg.sv
// Shared types for the savestate DDR arbiter slice.
// State enum and default channel widths.
package ss_pkg;
  localparam int SS_DDR_AW  = 19;
  localparam int SS_DDR_DW  = 64;
  localparam int SS_DDR_BEW = SS_DDR_DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ss_state_t;
endpackage

// File: rtl/ss_ddr_arbiter_if.sv
// Toggle-handshake DDRAM port: req/ack toggles, addr/we/be/wdata, rdata.
// master drives the request side, slave answers with ack/rdata.
interface ss_ddr_if
  import ss_pkg::*;
#(
  parameter int AW  = SS_DDR_AW,
  parameter int DW  = SS_DDR_DW,
  parameter int BEW = DW / 8
);
  logic           req;
  logic           ack;
  logic [AW-1:0]  addr;
  logic           we;
  logic [BEW-1:0] be;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/ss_ddr_arbiter_rr_pick.sv
// 2-way pick: round-robin (RR=1) or fixed client-0 priority (RR=0).
// Ports: elig0/elig1 in, take in (grant edge), pick/any out.
module ss_rr_pick #(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic elig0,
  input  logic elig1,
  input  logic take,
  output logic pick,
  output logic any
);
  // Reset to 1 so client 0 wins the first tie.
  logic last_q;

  assign any = elig0 | elig1;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      elig0 & elig1:  pick = RR ? ~last_q : 1'b0;
      ~elig0 & elig1: pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else if (take) last_q <= pick;
  end
endmodule

// File: rtl/ss_ddr_arbiter.sv
// Shares one toggle-handshake DDRAM channel between two clients.
// Ports: clk, reset_n, c0_lock, c0/c1 (slave), m (master), busy, owner.
module ss_ddr_arbiter
  import ss_pkg::*;
#(
  parameter int AW  = SS_DDR_AW,
  parameter int DW  = SS_DDR_DW,
  parameter int BEW = DW / 8,
  parameter int RR  = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     c0_lock,
  ss_ddr_if.slave  c0,
  ss_ddr_if.slave  c1,
  ss_ddr_if.master m,
  output logic     busy,
  output logic     owner
);
  ss_state_t      state;
  logic           req_q;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [BEW-1:0] be_q;
  logic [DW-1:0]  wdata_q;
  logic           c0_ack_q, c1_ack_q;
  logic [DW-1:0]  c0_rdata_q, c1_rdata_q;
  logic           owner_q;

  logic pend0, pend1, elig0, elig1;
  logic pick, any, take;

  assign pend0 = c0.req ^ c0_ack_q;
  assign pend1 = c1.req ^ c1_ack_q;
  assign elig0 = pend0;
  // Lock only blocks new grants; a client 1 already in WAIT finishes.
  assign elig1 = pend1 & ~c0_lock;
  assign take  = (state == IDLE) & any;

  ss_rr_pick #(
    .RR(RR != 0)
  ) u_pick (
    .clk     (clk),
    .reset_n (reset_n),
    .elig0   (elig0),
    .elig1   (elig1),
    .take    (take),
    .pick    (pick),
    .any     (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      c0_ack_q   <= 1'b0;
      c1_ack_q   <= 1'b0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
      owner_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= WAIT;
            req_q   <= ~req_q;
            owner_q <= pick;
            addr_q  <= pick ? c1.addr  : c0.addr;
            we_q    <= pick ? c1.we    : c0.we;
            be_q    <= pick ? c1.be    : c0.be;
            wdata_q <= pick ? c1.wdata : c0.wdata;
          end
        end
        WAIT: begin
          if (req_q == m.ack) begin
            state <= IDLE;
            if (owner_q) begin
              c1_ack_q <= ~c1_ack_q;
              if (!we_q) c1_rdata_q <= m.rdata;
            end else begin
              c0_ack_q <= ~c0_ack_q;
              if (!we_q) c0_rdata_q <= m.rdata;
            end
          end
        end
      endcase
    end
  end

  assign m.req    = req_q;
  assign m.addr   = addr_q;
  assign m.we     = we_q;
  assign m.be     = be_q;
  assign m.wdata  = wdata_q;
  assign c0.ack   = c0_ack_q;
  assign c0.rdata = c0_rdata_q;
  assign c1.ack   = c1_ack_q;
  assign c1.rdata = c1_rdata_q;
  assign busy     = (state == WAIT);
  assign owner    = owner_q;
endmodule

// File: tb/tb_ss_ddr_arbiter.sv
// Randomized bench for ss_ddr_arbiter with a transaction-level model
// of two toggle clients, the arbitration rules and an upstream memory.
module tb_ss_ddr_arbiter;
  import ss_pkg::*;

  localparam int AW  = SS_DDR_AW;
  localparam int DW  = SS_DDR_DW;
  localparam int BEW = SS_DDR_BEW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic c0_lock = 1'b0;
  logic busy, owner;

  ss_ddr_if c0_if ();
  ss_ddr_if c1_if ();
  ss_ddr_if m_if ();

  ss_ddr_arbiter #(
    .RR(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c0_lock (c0_lock),
    .c0      (c0_if),
    .c1      (c1_if),
    .m       (m_if),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]  mem [logic [AW-1:0]];
  logic [AW-1:0]  q_addr [2];
  logic           q_we [2];
  logic [BEW-1:0] q_be [2];
  logic [DW-1:0]  q_wdata [2];
  logic           pend [2];
  logic           exp_ack [2];
  logic [DW-1:0]  exp_rdata [2];
  logic           exp_mreq, m_busy, m_owner, last;
  int             up_cnt, up_dly;
  bit             up_rand;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {13'h0, a, 32'h5345_4E53};
  endfunction

  task automatic mem_wr(logic [AW-1:0] a, logic [BEW-1:0] be,
                        logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = mem_rd(a);
    for (int i = 0; i < BEW; i++)
      if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    mem[a] = v;
  endtask

  task automatic issue(int n, logic [AW-1:0] a, logic we,
                       logic [BEW-1:0] be, logic [DW-1:0] d);
    q_addr[n] = a;
    q_we[n] = we;
    q_be[n] = be;
    q_wdata[n] = d;
    pend[n] = 1'b1;
    if (n == 0) begin
      c0_if.addr = a; c0_if.we = we;
      c0_if.be = be; c0_if.wdata = d;
      c0_if.req = ~c0_if.req;
    end else begin
      c1_if.addr = a; c1_if.we = we;
      c1_if.be = be; c1_if.wdata = d;
      c1_if.req = ~c1_if.req;
    end
  endtask

  task automatic issue_rand(int n);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if (n == 1) a = a | AW'(19'h40000);
    issue(n, a, 1'($urandom_range(0, 1)),
          BEW'($urandom), {$urandom, $urandom});
  endtask

  // One clock: model the edge, compare outputs, then act as upstream.
  task automatic step();
    bit idle, done, p0, e1;
    bit w;
    idle = !m_busy;
    done = m_busy && (m_if.ack == exp_mreq);
    p0 = pend[0];
    e1 = pend[1] && !c0_lock;
    @(posedge clk);
    #1;
    if (done) begin
      exp_ack[m_owner] = ~exp_ack[m_owner];
      pend[m_owner] = 1'b0;
      if (!q_we[m_owner])
        exp_rdata[m_owner] = mem_rd(q_addr[m_owner]);
      m_busy = 1'b0;
    end else if (idle && (p0 || e1)) begin
      w = (p0 && e1) ? !last : e1;
      exp_mreq = ~exp_mreq;
      m_busy = 1'b1;
      m_owner = w;
      last = w;
      chk("g_addr", m_if.addr, q_addr[w]);
      chk("g_we", m_if.we, q_we[w]);
      chk("g_be", m_if.be, q_be[w]);
      chk("g_wdata", m_if.wdata, q_wdata[w]);
    end
    chk("m_req", m_if.req, exp_mreq);
    chk("c0_ack", c0_if.ack, exp_ack[0]);
    chk("c1_ack", c1_if.ack, exp_ack[1]);
    chk("c0_rdata", c0_if.rdata, exp_rdata[0]);
    chk("c1_rdata", c1_if.rdata, exp_rdata[1]);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    if (m_if.req != m_if.ack) begin
      if (up_cnt < 0) up_cnt = up_rand ? $urandom_range(0, 3) : up_dly;
      if (up_cnt == 0) begin
        if (m_if.we) begin
          mem_wr(m_if.addr, m_if.be, m_if.wdata);
          m_if.rdata = {$urandom, $urandom};
        end else begin
          m_if.rdata = mem_rd(m_if.addr);
        end
        m_if.ack = ~m_if.ack;
        up_cnt = -1;
      end else begin
        up_cnt--;
      end
    end
  endtask

  task automatic run_idle(int max);
    int k = 0;
    while ((m_busy || pend[0] || pend[1]) && k < max) begin
      step();
      k++;
    end
    if (m_busy || pend[0] || pend[1]) chk("timeout", 1, 0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_m_req", m_if.req, 0);
    chk("rst_c0_ack", c0_if.ack, 0);
    chk("rst_c1_ack", c1_if.ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c0_rdata", c0_if.rdata, 0);
    chk("rst_c1_rdata", c1_if.rdata, 0);
    exp_mreq = 0; m_busy = 0; m_owner = 0; last = 1;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; exp_ack[n] = 0; exp_rdata[n] = '0;
    end
    c0_if.req = 0; c1_if.req = 0;
    m_if.ack = 0; up_cnt = -1; c0_lock = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    c0_if.req = 0; c0_if.addr = '0; c0_if.we = 0;
    c0_if.be = '0; c0_if.wdata = '0;
    c1_if.req = 0; c1_if.addr = '0; c1_if.we = 0;
    c1_if.be = '0; c1_if.wdata = '0;
    m_if.ack = 0; m_if.rdata = '0;
    up_rand = 1; up_dly = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single client 0 read, upstream answers 3 cycles after issue.
    mem[1] = 64'h0000_0000_5345_4E53;
    up_rand = 0; up_dly = 3;
    issue(0, 19'h00001, 1'b0, 8'hFF, '0);
    run_idle(20);
    chk("t1_c0_rdata", c0_if.rdata, 64'h5345_4E53);
    up_rand = 1;

    // Simultaneous client 0 write and client 1 read after reset.
    do_reset();
    issue(0, 19'h00002, 1'b1, 8'hF0, 64'hA5A5_5A5A_1234_5678);
    issue(1, 19'h40001, 1'b0, 8'hFF, '0);
    step();
    chk("t2_first", owner, 0);
    run_idle(20);
    chk("t2_second", owner, 1);
    chk("t2_c0_keep", c0_if.rdata, 0);

    // Both clients kept pending back to back.
    repeat (24) begin
      if (!pend[0]) issue_rand(0);
      if (!pend[1]) issue_rand(1);
      step();
    end
    run_idle(20);

    // Lock holds client 1 off for 50 cycles.
    c0_lock = 1;
    issue_rand(1);
    repeat (50) step();
    chk("t4_held", c1_if.ack, 0 ^ exp_ack[1]);
    c0_lock = 0;
    step();
    chk("t4_grant", owner, 1);
    run_idle(20);

    // Lock rises while client 1 is in WAIT.
    issue(1, 19'h40003, 1'b0, 8'hFF, '0);
    step();
    c0_lock = 1;
    issue(0, 19'h00003, 1'b0, 8'hFF, '0);
    run_idle(30);
    c0_lock = 0;

    // Reset during WAIT, then a fresh read.
    up_rand = 0; up_dly = 3;
    issue(0, 19'h00004, 1'b0, 8'hFF, '0);
    step();
    step();
    do_reset();
    up_rand = 1;
    issue(0, 19'h00001, 1'b0, 8'hFF, '0);
    run_idle(20);

    // Random traffic with random lock windows.
    repeat (3000) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 99) < 40) issue_rand(n);
      if ($urandom_range(0, 99) < 3) c0_lock = ~c0_lock;
      step();
    end
    c0_lock = 0;
    run_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
